// File: rtl/irq_ctrl.sv
// Prioritised, maskable multi-channel interrupt controller.
// Feeds one request plus vector address to the core; retires it on irq_ack.
module irq_ctrl #(
    parameter int unsigned        NUM_IRQ    = 4,
    parameter int unsigned        ID_W       = 2,
    parameter logic [NUM_IRQ-1:0] EDGE_MASK  = '1,
    parameter logic [NUM_IRQ-1:0] MASK_RST   = '1,
    parameter logic [31:0]        VEC_BASE   = 32'h0000_1000,
    parameter logic [31:0]        VEC_STRIDE = 32'h0000_0020
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq_src,
    input  logic               mask_we,
    input  logic [NUM_IRQ-1:0] mask_wd,
    output logic [NUM_IRQ-1:0] mask_q,
    output logic [NUM_IRQ-1:0] pend_q,
    output logic               irq,
    output logic [31:0]        irq_addr,
    output logic [ID_W-1:0]    irq_id,
    input  logic               irq_ack,
    output logic               busy
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        GAP
    } state_t;

    state_t state_q, state_d;

    logic [NUM_IRQ-1:0] s1_q, s1_d;
    logic [NUM_IRQ-1:0] s2_q, s2_d;
    logic [NUM_IRQ-1:0] prev_q, prev_d;
    logic [NUM_IRQ-1:0] pend_d;
    logic [NUM_IRQ-1:0] mask_d;
    logic [ID_W-1:0]    irq_id_q, irq_id_d;
    logic [31:0]        irq_addr_q, irq_addr_d;

    logic [NUM_IRQ-1:0] set_vec;
    logic [NUM_IRQ-1:0] clr_vec;
    logic [NUM_IRQ-1:0] eligible;
    logic [ID_W-1:0]    winner;
    logic               ack_go;

    always_comb begin
        s1_d   = irq_src;
        s2_d   = s1_q;
        prev_d = s2_q;
    end

    // Edge channels fire on a 0->1 of the synchronised source; level ones every high cycle.
    always_comb begin
        set_vec = (s2_q & ~prev_q & EDGE_MASK) | (s2_q & ~EDGE_MASK);
    end

    always_comb begin
        eligible = pend_q & mask_q;
        winner   = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                winner = ID_W'(i);
            end
        end
    end

    // Set wins over the retire-clear of the in-service bit.
    always_comb begin
        ack_go  = (state_q == REQ) && irq_ack;
        clr_vec = '0;
        if (ack_go) begin
            clr_vec[irq_id_q] = 1'b1;
        end
        pend_d = (pend_q & ~clr_vec) | set_vec;
        mask_d = mask_we ? mask_wd : mask_q;
    end

    always_comb begin
        state_d    = state_q;
        irq_id_d   = irq_id_q;
        irq_addr_d = irq_addr_q;
        unique case (state_q)
            IDLE: begin
                if (|eligible) begin
                    state_d    = REQ;
                    irq_id_d   = winner;
                    irq_addr_d = VEC_BASE
                               + ({{(32 - ID_W){1'b0}}, winner} * VEC_STRIDE);
                end
            end
            REQ: begin
                if (irq_ack) begin
                    state_d = GAP;
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            s1_q       <= '0;
            s2_q       <= '0;
            prev_q     <= '0;
            pend_q     <= '0;
            mask_q     <= MASK_RST;
            irq_id_q   <= '0;
            irq_addr_q <= VEC_BASE;
        end else begin
            state_q    <= state_d;
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            prev_q     <= prev_d;
            pend_q     <= pend_d;
            mask_q     <= mask_d;
            irq_id_q   <= irq_id_d;
            irq_addr_q <= irq_addr_d;
        end
    end

    assign irq      = (state_q == REQ);
    assign busy     = (state_q != IDLE);
    assign irq_id   = irq_id_q;
    assign irq_addr = irq_addr_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: channel 0 level, channels 1-3 edge.
module tb_irq_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  irq_src = '0;
    logic        mask_we = 1'b0;
    logic [3:0]  mask_wd = '0;
    logic [3:0]  mask_q;
    logic [3:0]  pend_q;
    logic        irq;
    logic [31:0] irq_addr;
    logic [1:0]  irq_id;
    logic        irq_ack = 1'b0;
    logic        busy;

    int checks = 0;
    int errors = 0;

    irq_ctrl #(
        .NUM_IRQ   (4),
        .ID_W      (2),
        .EDGE_MASK (4'b1110),
        .MASK_RST  (4'b1111),
        .VEC_BASE  (32'h0000_1000),
        .VEC_STRIDE(32'h0000_0020)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .irq_src (irq_src),
        .mask_we (mask_we),
        .mask_wd (mask_wd),
        .mask_q  (mask_q),
        .pend_q  (pend_q),
        .irq     (irq),
        .irq_addr(irq_addr),
        .irq_id  (irq_id),
        .irq_ack (irq_ack),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic ack_pulse();
        irq_ack = 1'b1;
        tick(1);
        irq_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick(3);
        rst = 1'b1;
        tick(1);
        checks++;
        if (pend_q !== 4'b0000) begin
            errors++; $display("FAIL rst_pend: got %b want 0000", pend_q);
        end
        checks++;
        if (mask_q !== 4'b1111) begin
            errors++; $display("FAIL rst_mask: got %b want 1111", mask_q);
        end
        checks++;
        if (irq !== 1'b0 || busy !== 1'b0 || irq_id !== 2'd0) begin
            errors++;
            $display("FAIL rst_ctl: irq=%b busy=%b id=%0d want 0 0 0", irq, busy, irq_id);
        end
        checks++;
        if (irq_addr !== 32'h1000) begin
            errors++; $display("FAIL rst_addr: got %h want 00001000", irq_addr);
        end
    endtask

    task automatic test_single_edge();
        irq_src[2] = 1'b1;
        tick(3);
        checks++;
        if (pend_q !== 4'b0100 || irq !== 1'b0) begin
            errors++; $display("FAIL edge_pend: pend=%b irq=%b want 0100 0", pend_q, irq);
        end
        tick(1);
        checks++;
        if (irq !== 1'b1 || irq_id !== 2'd2 || irq_addr !== 32'h1040 || busy !== 1'b1) begin
            errors++;
            $display("FAIL edge_req: irq=%b id=%0d addr=%h busy=%b want 1 2 00001040 1",
                     irq, irq_id, irq_addr, busy);
        end
        tick(5);
        irq_src[2] = 1'b0;
        ack_pulse();
        checks++;
        if (pend_q !== 4'b0000 || irq !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL edge_ack: pend=%b irq=%b busy=%b want 0000 0 1", pend_q, irq, busy);
        end
        checks++;
        if (irq_id !== 2'd2 || irq_addr !== 32'h1040) begin
            errors++; $display("FAIL edge_hold: id=%0d addr=%h want 2 00001040", irq_id, irq_addr);
        end
        tick(1);
        checks++;
        if (busy !== 1'b0 || irq !== 1'b0) begin
            errors++; $display("FAIL edge_idle: busy=%b irq=%b want 0 0", busy, irq);
        end
        tick(3);
    endtask

    task automatic test_priority();
        irq_src = 4'b1010;
        tick(3);
        checks++;
        if (pend_q !== 4'b1010) begin
            errors++; $display("FAIL prio_pend: got %b want 1010", pend_q);
        end
        tick(1);
        checks++;
        if (irq !== 1'b1 || irq_id !== 2'd1 || irq_addr !== 32'h1020) begin
            errors++;
            $display("FAIL prio_first: irq=%b id=%0d addr=%h want 1 1 00001020", irq, irq_id, irq_addr);
        end
        irq_src = 4'b0001;
        tick(1);
        irq_src = 4'b0000;
        tick(3);
        checks++;
        if (pend_q !== 4'b1011 || irq_id !== 2'd1 || irq_addr !== 32'h1020 || irq !== 1'b1) begin
            errors++;
            $display("FAIL prio_nopreempt: pend=%b id=%0d addr=%h irq=%b want 1011 1 00001020 1",
                     pend_q, irq_id, irq_addr, irq);
        end
        ack_pulse();
        checks++;
        if (pend_q !== 4'b1001 || irq !== 1'b0) begin
            errors++; $display("FAIL prio_ack1: pend=%b irq=%b want 1001 0", pend_q, irq);
        end
        tick(1);
        checks++;
        if (irq !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL prio_gap: irq=%b busy=%b want 0 0", irq, busy);
        end
        tick(1);
        checks++;
        if (irq !== 1'b1 || irq_id !== 2'd0 || irq_addr !== 32'h1000) begin
            errors++;
            $display("FAIL prio_second: irq=%b id=%0d addr=%h want 1 0 00001000", irq, irq_id, irq_addr);
        end
        ack_pulse();
        tick(2);
        checks++;
        if (irq !== 1'b1 || irq_id !== 2'd3 || irq_addr !== 32'h1060 || pend_q !== 4'b1000) begin
            errors++;
            $display("FAIL prio_third: irq=%b id=%0d addr=%h pend=%b want 1 3 00001060 1000",
                     irq, irq_id, irq_addr, pend_q);
        end
        ack_pulse();
        tick(2);
        checks++;
        if (pend_q !== 4'b0000 || irq !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL prio_done: pend=%b irq=%b busy=%b want 0000 0 0", pend_q, irq, busy);
        end
    endtask

    task automatic test_mask();
        mask_we = 1'b1;
        mask_wd = 4'b1110;
        tick(1);
        mask_we = 1'b0;
        checks++;
        if (mask_q !== 4'b1110) begin
            errors++; $display("FAIL mask_write: got %b want 1110", mask_q);
        end
        irq_src[0] = 1'b1;
        tick(1);
        irq_src[0] = 1'b0;
        tick(2);
        checks++;
        if (pend_q !== 4'b0001) begin
            errors++; $display("FAIL mask_pend: got %b want 0001", pend_q);
        end
        for (int i = 0; i < 10; i++) begin
            tick(1);
            checks++;
            if (irq !== 1'b0) begin
                errors++; $display("FAIL mask_block: cycle %0d irq=%b want 0", i, irq);
            end
        end
        mask_we = 1'b1;
        mask_wd = 4'b1111;
        tick(1);
        mask_we = 1'b0;
        checks++;
        if (irq !== 1'b0 || mask_q !== 4'b1111) begin
            errors++; $display("FAIL mask_edge1: irq=%b mask=%b want 0 1111", irq, mask_q);
        end
        tick(1);
        checks++;
        if (irq !== 1'b1 || irq_id !== 2'd0) begin
            errors++; $display("FAIL mask_unmask: irq=%b id=%0d want 1 0", irq, irq_id);
        end
        ack_pulse();
        tick(2);
    endtask

    task automatic test_set_wins();
        irq_src[2] = 1'b1;
        tick(4);
        checks++;
        if (irq !== 1'b1 || irq_id !== 2'd2) begin
            errors++; $display("FAIL sw_req: irq=%b id=%0d want 1 2", irq, irq_id);
        end
        irq_src[2] = 1'b0;
        tick(4);
        irq_src[2] = 1'b1;
        tick(2);
        ack_pulse();
        checks++;
        if (pend_q[2] !== 1'b1 || irq !== 1'b0) begin
            errors++; $display("FAIL sw_pend: pend=%b irq=%b want x1xx 0", pend_q, irq);
        end
        tick(2);
        checks++;
        if (irq !== 1'b1 || irq_id !== 2'd2) begin
            errors++; $display("FAIL sw_rereq: irq=%b id=%0d want 1 2", irq, irq_id);
        end
        irq_src[2] = 1'b0;
        ack_pulse();
        checks++;
        if (pend_q !== 4'b0000) begin
            errors++; $display("FAIL sw_clear: got %b want 0000", pend_q);
        end
        tick(2);
    endtask

    task automatic test_level();
        irq_src[0] = 1'b1;
        tick(4);
        checks++;
        if (irq !== 1'b1 || irq_id !== 2'd0) begin
            errors++; $display("FAIL lvl_req: irq=%b id=%0d want 1 0", irq, irq_id);
        end
        ack_pulse();
        checks++;
        if (pend_q !== 4'b0001 || irq !== 1'b0) begin
            errors++; $display("FAIL lvl_repend: pend=%b irq=%b want 0001 0", pend_q, irq);
        end
        tick(2);
        checks++;
        if (irq !== 1'b1 || irq_id !== 2'd0) begin
            errors++; $display("FAIL lvl_rereq: irq=%b id=%0d want 1 0", irq, irq_id);
        end
        irq_src[0] = 1'b0;
        tick(3);
        ack_pulse();
        checks++;
        if (pend_q !== 4'b0000) begin
            errors++; $display("FAIL lvl_clear: got %b want 0000", pend_q);
        end
        tick(3);
        checks++;
        if (irq !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL lvl_idle: irq=%b busy=%b want 0 0", irq, busy);
        end
    endtask

    task automatic test_ack_idle();
        irq_src[1] = 1'b1;
        tick(3);
        irq_ack = 1'b1;
        tick(1);
        irq_ack = 1'b0;
        checks++;
        if (irq !== 1'b1 || pend_q !== 4'b0010) begin
            errors++; $display("FAIL ack_idle: irq=%b pend=%b want 1 0010", irq, pend_q);
        end
        irq_src[1] = 1'b0;
        ack_pulse();
        tick(2);
    endtask

    task automatic test_reset_mid();
        irq_src[3] = 1'b1;
        tick(4);
        checks++;
        if (irq !== 1'b1 || irq_id !== 2'd3) begin
            errors++; $display("FAIL rm_req: irq=%b id=%0d want 1 3", irq, irq_id);
        end
        #1;
        rst = 1'b0;
        #1;
        checks++;
        if (irq !== 1'b0 || pend_q !== 4'b0000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rm_async: irq=%b pend=%b busy=%b want 0 0000 0", irq, pend_q, busy);
        end
        checks++;
        if (irq_addr !== 32'h1000 || irq_id !== 2'd0) begin
            errors++; $display("FAIL rm_vec: addr=%h id=%0d want 00001000 0", irq_addr, irq_id);
        end
        irq_src[3] = 1'b0;
        tick(2);
        rst = 1'b1;
        tick(4);
        checks++;
        if (irq !== 1'b0 || pend_q !== 4'b0000) begin
            errors++; $display("FAIL rm_after: irq=%b pend=%b want 0 0000", irq, pend_q);
        end
    endtask

    initial begin
        test_reset();
        test_single_edge();
        test_priority();
        test_mask();
        test_set_wins();
        test_level();
        test_ack_idle();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
